// File: rtl/cpu_ctrl_pkg.sv
// Shared constants and types for the hardwired fetch/execute control unit.
package cpu_ctrl_pkg;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam int RA_HI  = 26;
    localparam int RA_LO  = 23;
    localparam int RB_HI  = 22;
    localparam int RB_LO  = 19;
    localparam int RC_HI  = 18;
    localparam int RC_LO  = 15;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_ROL  = 5'b00111;
    localparam logic [4:0] OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6
    } state_e;

    typedef enum logic [3:0] {
        ALU_NONE = 4'd0, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SHR, ALU_SHL,
        ALU_ROR, ALU_ROL, ALU_MUL, ALU_DIV, ALU_NEG, ALU_NOT
    } alu_op_e;

    typedef enum logic [2:0] {
        C_ALU3, C_MULDIV, C_UNARY, C_NOP, C_HALT, C_ILLEGAL
    } op_class_e;

endpackage

// File: rtl/ctrl_decode.sv
// Opcode decoder: instruction class that shapes the execute steps, plus ALU op.
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [4:0] opcode,
    output op_class_e  op_class,
    output alu_op_e    alu_op
);

    always_comb begin
        op_class = C_ILLEGAL;
        alu_op   = ALU_NONE;
        case (opcode)
            OP_ADD:  begin op_class = C_ALU3;   alu_op = ALU_ADD; end
            OP_SUB:  begin op_class = C_ALU3;   alu_op = ALU_SUB; end
            OP_SHR:  begin op_class = C_ALU3;   alu_op = ALU_SHR; end
            OP_SHL:  begin op_class = C_ALU3;   alu_op = ALU_SHL; end
            OP_ROL:  begin op_class = C_ALU3;   alu_op = ALU_ROL; end
            OP_ROR:  begin op_class = C_ALU3;   alu_op = ALU_ROR; end
            OP_AND:  begin op_class = C_ALU3;   alu_op = ALU_AND; end
            OP_OR:   begin op_class = C_ALU3;   alu_op = ALU_OR;  end
            OP_MUL:  begin op_class = C_MULDIV; alu_op = ALU_MUL; end
            OP_DIV:  begin op_class = C_MULDIV; alu_op = ALU_DIV; end
            OP_NEG:  begin op_class = C_UNARY;  alu_op = ALU_NEG; end
            OP_NOT:  begin op_class = C_UNARY;  alu_op = ALU_NOT; end
            OP_NOP:  op_class = C_NOP;
            OP_HALT: op_class = C_HALT;
            default: op_class = C_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore control unit: fetch (T0..T2) then class-specific execute steps,
// with run/halt/stop handling. Outputs decode from the state register and ir.
module control_unit
    import cpu_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] ir,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        Zin,
    output logic        PCin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        LOin,
    output logic        HIin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic [3:0]  alu_op,
    output logic        run,
    output logic        halted,
    output logic        illegal
);

    state_e    state_q, state_d;
    logic      halted_q, halted_d;
    logic      last;
    op_class_e op_class;
    alu_op_e   dec_alu;

    // Register fields are consumed by the datapath's select logic, not here.
    logic unused_ir;
    assign unused_ir = ^ir[RA_HI:0];

    ctrl_decode u_dec (
        .opcode   (ir[OPC_HI:OPC_LO]),
        .op_class (op_class),
        .alu_op   (dec_alu)
    );

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q  <= S_IDLE;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        last     = 1'b0;
        case (state_q)
            S_IDLE: if (start && !stop) begin
                state_d  = S_T0;
                halted_d = 1'b0;
            end
            S_T0: state_d = S_T1;
            S_T1: state_d = S_T2;
            S_T2: case (op_class)
                C_ALU3, C_MULDIV, C_UNARY: state_d = S_T3;
                C_HALT: begin
                    state_d  = S_IDLE;
                    halted_d = 1'b1;
                end
                default: last = 1'b1;
            endcase
            S_T3: state_d = S_T4;
            S_T4: if (op_class == C_UNARY) last = 1'b1; else state_d = S_T5;
            S_T5: if (op_class == C_ALU3) last = 1'b1; else state_d = S_T6;
            S_T6: last = 1'b1;
            default: state_d = S_IDLE;
        endcase
        // stop only matters on the final step, so an instruction always completes
        if (last) state_d = stop ? S_IDLE : S_T0;
    end

    always_comb begin
        {PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin,
         Zlowout, Zhighout, LOin, HIin, Gra, Grb, Grc, Rin, Rout} = '0;
        alu_op  = ALU_NONE;
        illegal = 1'b0;
        run     = (state_q != S_IDLE);
        halted  = halted_q;
        case (state_q)
            S_T0: {PCout, MARin, IncPC, Zin} = '1;
            S_T1: {Zlowout, PCin, Read, MDRin} = '1;
            S_T2: begin
                {MDRout, IRin} = '1;
                illegal = (op_class == C_ILLEGAL);
            end
            S_T3: case (op_class)
                C_ALU3:   {Grb, Rout, Yin} = '1;
                C_MULDIV: {Gra, Rout, Yin} = '1;
                C_UNARY: begin
                    {Grb, Rout, Zin} = '1;
                    alu_op = dec_alu;
                end
                default: ;
            endcase
            S_T4: case (op_class)
                C_ALU3: begin
                    {Grc, Rout, Zin} = '1;
                    alu_op = dec_alu;
                end
                C_MULDIV: begin
                    {Grb, Rout, Zin} = '1;
                    alu_op = dec_alu;
                end
                C_UNARY: {Zlowout, Gra, Rin} = '1;
                default: ;
            endcase
            S_T5: case (op_class)
                C_ALU3:   {Zlowout, Gra, Rin} = '1;
                C_MULDIV: {Zlowout, LOin} = '1;
                default: ;
            endcase
            S_T6: if (op_class == C_MULDIV) {Zhighout, HIin} = '1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Randomized scoreboard bench for control_unit against a per-instruction step-list model.
module tb_control_unit;

    logic clock = 1'b0, clear = 1'b0, start = 1'b0, stop = 1'b0;
    logic [31:0] ir = '0;
    logic PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin;
    logic Zlowout, Zhighout, LOin, HIin, Gra, Grb, Grc, Rin, Rout;
    logic [3:0] alu_op;
    logic run, halted, illegal;

    control_unit dut (
        .clock(clock), .clear(clear), .start(start), .stop(stop), .ir(ir),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .PCin(PCin),
        .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
        .Zlowout(Zlowout), .Zhighout(Zhighout), .LOin(LOin), .HIin(HIin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .alu_op(alu_op), .run(run), .halted(halted), .illegal(illegal)
    );

    always #5 clock = ~clock;

    localparam int B_PCOUT = 0, B_MARIN = 1, B_INCPC = 2, B_ZIN = 3, B_PCIN = 4;
    localparam int B_READ = 5, B_MDRIN = 6, B_MDROUT = 7, B_IRIN = 8, B_YIN = 9;
    localparam int B_ZLO = 10, B_ZHI = 11, B_LOIN = 12, B_HIIN = 13, B_GRA = 14;
    localparam int B_GRB = 15, B_GRC = 16, B_RIN = 17, B_ROUT = 18, B_ALU = 19;
    localparam int B_RUN = 23, B_HALTED = 24, B_ILLEGAL = 25;

    logic [25:0] act_v;
    assign act_v = {illegal, halted, run, alu_op, Rout, Rin, Grc, Grb, Gra, HIin, LOin,
                    Zhighout, Zlowout, Yin, IRin, MDRout, MDRin, Read, PCin, Zin,
                    IncPC, MARin, PCout};

    typedef struct {
        logic [31:0] ir;
        bit          stop_end;
        bit          noise;
        int          clear_at;
    } instr_t;

    int n_vec = 0, n_bad = 0, cyc = 0;
    logic [25:0] exp_q[$];
    logic [25:0] steps[$];
    instr_t prog[$];
    instr_t cur;
    bit running = 0, pend_begin = 0, halted_m = 0;
    int idx = 0, n_done = 0, n_rand = 0;
    localparam int N_RAND = 140;

    function automatic logic [25:0] m(input int b);
        return 26'(1) << b;
    endfunction

    // Expected cycle-by-cycle output words for one instruction, from the opcode table.
    function automatic void build(input logic [31:0] i);
        logic [4:0] o;
        int kind, a;
        o = i[31:27];
        kind = 0; a = 0;
        case (o)
            5'b00011: begin kind = 1; a = 1;  end
            5'b00100: begin kind = 1; a = 2;  end
            5'b00101: begin kind = 1; a = 5;  end
            5'b00110: begin kind = 1; a = 6;  end
            5'b00111: begin kind = 1; a = 8;  end
            5'b01000: begin kind = 1; a = 7;  end
            5'b01001: begin kind = 1; a = 3;  end
            5'b01010: begin kind = 1; a = 4;  end
            5'b01110: begin kind = 2; a = 9;  end
            5'b01111: begin kind = 2; a = 10; end
            5'b10000: begin kind = 3; a = 11; end
            5'b10001: begin kind = 3; a = 12; end
            5'b11010: kind = 4;
            5'b11011: kind = 5;
            default:  kind = 0;
        endcase
        steps.delete();
        steps.push_back(m(B_PCOUT) | m(B_MARIN) | m(B_INCPC) | m(B_ZIN));
        steps.push_back(m(B_ZLO) | m(B_PCIN) | m(B_READ) | m(B_MDRIN));
        steps.push_back(m(B_MDROUT) | m(B_IRIN) | ((kind == 0) ? m(B_ILLEGAL) : 26'd0));
        if (kind == 1) begin
            steps.push_back(m(B_GRB) | m(B_ROUT) | m(B_YIN));
            steps.push_back(m(B_GRC) | m(B_ROUT) | m(B_ZIN) | (26'(a) << B_ALU));
            steps.push_back(m(B_ZLO) | m(B_GRA) | m(B_RIN));
        end else if (kind == 2) begin
            steps.push_back(m(B_GRA) | m(B_ROUT) | m(B_YIN));
            steps.push_back(m(B_GRB) | m(B_ROUT) | m(B_ZIN) | (26'(a) << B_ALU));
            steps.push_back(m(B_ZLO) | m(B_LOIN));
            steps.push_back(m(B_ZHI) | m(B_HIIN));
        end else if (kind == 3) begin
            steps.push_back(m(B_GRB) | m(B_ROUT) | m(B_ZIN) | (26'(a) << B_ALU));
            steps.push_back(m(B_ZLO) | m(B_GRA) | m(B_RIN));
        end
    endfunction

    function automatic instr_t next_instr();
        instr_t t;
        logic [4:0] valid_ops[14] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                                      5'b01000, 5'b01001, 5'b01010, 5'b01110, 5'b01111,
                                      5'b10000, 5'b10001, 5'b11010, 5'b11011};
        if (prog.size() > 0) return prog.pop_front();
        t.ir = $urandom;
        if ($urandom_range(15) < 12) t.ir[31:27] = valid_ops[$urandom_range(13)];
        t.stop_end = ($urandom_range(4) == 0);
        t.noise    = 1'b0;
        t.clear_at = -1;
        n_rand++;
        return t;
    endfunction

    // Monitor: one scoreboard entry per clock, compared mid-cycle.
    always @(negedge clock) begin
        cyc++;
        if (exp_q.size() > 0) begin
            logic [25:0] e;
            e = exp_q.pop_front();
            n_vec++;
            if (act_v !== e) begin
                n_bad++;
                $display("FAIL outputs cycle %0d: got %h expected %h", cyc, act_v, e);
            end
        end
    end

    task automatic step();
        logic [25:0] e;
        bit is_last;
        @(posedge clock);
        #1;
        clear = 1'b1;
        if (pend_begin) begin
            cur = next_instr();
            build(cur.ir);
            running = 1; idx = 0; pend_begin = 0;
        end
        if (running) begin
            ir    = cur.ir;
            start = 1'($urandom_range(1));
            if (cur.clear_at == idx) begin
                start = 0; stop = 0;
                exp_q.push_back(26'd0);
                #2 clear = 1'b0;
                running = 0; halted_m = 0; steps.delete(); n_done++;
                return;
            end
            e = steps.pop_front() | m(B_RUN);
            is_last = (steps.size() == 0);
            stop = is_last ? cur.stop_end : (cur.noise ? 1'b1 : ($urandom_range(3) == 0));
            exp_q.push_back(e);
            idx++;
            if (is_last) begin
                n_done++;
                running = 0;
                if (cur.ir[31:27] == 5'b11011) halted_m = 1;
                else if (!stop) pend_begin = 1;
            end
        end else begin
            ir    = $urandom;
            start = ($urandom_range(2) == 0);
            stop  = ($urandom_range(3) == 0);
            exp_q.push_back(halted_m ? m(B_HALTED) : 26'd0);
            if (start && !stop) begin
                pend_begin = 1;
                halted_m   = 0;
            end
        end
    endtask

    initial begin
        prog.push_back('{32'h50918000, 1'b0, 1'b0, -1});   // OR R1,R2,R3
        prog.push_back('{32'h72280000, 1'b0, 1'b0, -1});   // MUL R4,R5
        prog.push_back('{32'h18918000, 1'b0, 1'b1, -1});   // ADD, stop high until last step
        prog.push_back('{32'h18918000, 1'b1, 1'b0, -1});   // ADD, stop held at T5
        prog.push_back('{32'hD8000000, 1'b0, 1'b0, -1});   // HALT
        prog.push_back('{32'hF8000000, 1'b0, 1'b0, -1});   // opcode 11111
        prog.push_back('{32'h80880000, 1'b0, 1'b0, -1});   // NEG
        prog.push_back('{32'hD0000000, 1'b0, 1'b0, -1});   // NOP
        prog.push_back('{32'h18918000, 1'b0, 1'b0, 4});    // ADD, clear dropped in T4
        // Reset held with start asserted: everything must stay 0.
        start = 1; ir = $urandom;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock);
            #1;
            exp_q.push_back(26'd0);
        end
        while (n_done < 9 + N_RAND) step();
        repeat (2) @(posedge clock);
        if (exp_q.size() != 0) begin
            n_vec++; n_bad++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired Moore control unit that sequences the datapath through instruction fetch and execute for register-register ALU instructions. It sits beside `datapath` and replaces the hand-driven T0..T6 stimulus with a state machine. The state machine decodes the instruction register and drives every datapath strobe: bus-out selects, register loads, `Read`, and the ALU operation. It also handles run/halt control.

## Interface
- Parameters: none.
- `clock`  in  1  system clock; all state changes on rising edge.
- `clear`  in  1  asynchronous, active-low reset.
- `start`  in  1  level; leave IDLE and begin fetch.
- `stop`  in  1  level; finish current instruction, then go to IDLE.
- `ir`  in  32  IR contents from datapath.
  - `ir[31:27]` opcode, `ir[26:23]` ra, `ir[22:19]` rb, `ir[18:15]` rc.
- `PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin, Zlowout, Zhighout, LOin, HIin`  out  1 each  datapath strobes.
- `Gra, Grb, Grc, Rin, Rout`  out  1 each  register-field select and general-register in/out, to the datapath select-and-encode logic.
- `alu_op`  out  4  ALU operation.
- `run`  out  1  high in every state except IDLE.
- `halted`  out  1  sticky; set by `halt`, cleared by `start` or reset.
- `illegal`  out  1  high for the T2 cycle of an undefined opcode.

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, T6.
- All outputs are decoded combinationally from the state register and `ir`. In T3..T6, `ir` is stable because IRin loads at the end of T2.
- Any strobe not listed for a state is 0. `alu_op` = NONE (0) unless listed.
- IDLE: all strobes 0. Move to T0 when `start`=1.
- Fetch, same for every opcode:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
- Opcodes and execute steps:
  - 00011 add, 00100 sub, 00101 shr, 00110 shl, 00111 rol, 01000 ror, 01001 and, 01010 or:
    - T3: Grb, Rout, Yin.
    - T4: Grc, Rout, Zin, alu_op=op.
    - T5: Zlowout, Gra, Rin.
  - 01110 mul, 01111 div:
    - T3: Gra, Rout, Yin.
    - T4: Grb, Rout, Zin, alu_op=op.
    - T5: Zlowout, LOin.
    - T6: Zhighout, HIin.
  - 10000 neg, 10001 not:
    - T3: Grb, Rout, Zin, alu_op=op.
    - T4: Zlowout, Gra, Rin.
  - 11010 nop: T2 -> T0.
  - 11011 halt: T2 -> IDLE; set `halted`.
  - Any other opcode: treated as nop, with `illegal` high during T2.
- Last state of each instruction:
  - `stop`=1 sampled in that cycle -> next state IDLE. `halted` is not set.
  - Otherwise -> T0.
- `stop` in earlier cycles is ignored; an instruction always completes.
- `start` and `stop` both high in IDLE: `stop` wins, stay in IDLE.
- `start` in IDLE clears `halted` on the same edge that enters T0.

## Timing
- Reset: `clear`=0 forces state IDLE and `halted`=0 immediately, with no clock. All outputs read 0 while `clear` is low.
- Reset mid-instruction: the instruction is abandoned; the datapath keeps whatever it had already latched.
- Every state lasts exactly one clock.
- Cycles per instruction, T0 to next T0:
  - three-operand ALU ops: 6.
  - mul/div: 7.
  - neg/not: 5.
  - nop and illegal opcodes: 3.
  - halt: 3, then IDLE.
- First T0 begins one clock after `start` is sampled high in IDLE.
- Strobes change only after rising edges (Moore outputs). Datapath registers capture at the next edge.

## Structure
- Package `cpu_ctrl_pkg` holds:
  - opcode constants (5-bit);
  - state enum (3-bit, IDLE=0);
  - `alu_op` constants (4-bit): NONE=0, ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, MUL, DIV, NEG, NOT;
  - IR field bit positions.
- Sub-module `ctrl_decode` (combinational) maps an opcode to a class (ALU3, MULDIV, UNARY, NOP, HALT, ILLEGAL) and an `alu_op`.
- `control_unit` holds only the state register, the `halted` flag and the output decode.

## Test plan
- Reset:
  - Hold `clear`=0 -> all outputs 0, `run`=0.
  - Release, `start`=1 one cycle -> T0 next cycle, with PCout/MARin/IncPC/Zin=1.
- OR R1,R2,R3 (`ir`=32'h50918000):
  - T3: Grb/Rout/Yin.
  - T4: Grc/Rout/Zin, `alu_op`=OR.
  - T5: Zlowout/Gra/Rin.
  - T0 again 6 clocks after the first T0.
- MUL R4,R5 (opcode 01110):
  - LOin in T5, HIin in T6, 7-cycle period.
  - No Rin at any point.
- HALT (`ir`=32'hD8000000):
  - IDLE after T2, `halted`=1, `run`=0.
  - Later `start` -> `halted`=0, T0.
- `stop` pulsed during T4 of an ADD -> T5 completes with Rin, then T5 -> T0; `stop` still held at T5 -> IDLE with `halted`=0.
- Boundary cases:
  - Opcode 11111 -> `illegal`=1 in T2 only, then T0.
  - `clear` dropped mid-T4 -> outputs 0 within the same cycle, state IDLE.
